adder_result_checker: RTL

- Self-checking stage directly downstream of the 32-bit 2-stage pipelined adder.
- Receives the same operand stream that feeds the adder and computes a golden sum. It delays that sum to match the adder's 3-clock operand-to-output latency, then compares it with the adder's registered sum and carry.
- Reports pass/fail counts, a sticky error flag and the first mismatching pair. The display logic can then show either the sum or the diagnostics.

---
 rtl/adder_result_checker_pkg.sv | 17 +
 rtl/adder_result_checker_if.sv | 15 +
 rtl/adder_result_checker_result_delay_line.sv | 51 +++++
 rtl/adder_result_checker.sv | 109 ++++++++++
 4 files changed

// File: rtl/adder_result_checker_pkg.sv
// Shared constants and state encoding for the adder result checker.
// The adder and its checker both take ADDER_LATENCY from here so their
// operand-to-result alignment cannot drift apart.
package adder_result_checker_pkg;

   localparam int ADDER_WIDTH   = 32;
   localparam int ADDER_LATENCY = 3;   // input reg, pipeline reg, output reg
   localparam int CHK_CNT_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } chk_state_t;

endpackage

// File: rtl/adder_result_checker_if.sv
// Operand stream into the adder plus the adder's registered result.
// The stimulus/adder side is the master; the checker only observes.
interface adder_result_checker_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic [WIDTH-1:0] sum_in;
   logic             cout_in;

   modport master (output in_valid, a, b, c_in, sum_in, cout_in);
   modport slave  (input  in_valid, a, b, c_in, sum_in, cout_in);
endinterface

// File: rtl/adder_result_checker_result_delay_line.sv
// Valid+data shift register that carries golden results alongside the
// adder pipeline. Only the valid bits are reset; data is don't-care while
// its valid bit is low. flush drops everything already in flight but still
// captures the current input, so a restart cycle's own vector survives.
module result_delay_line #(
   parameter int DW    = 33,
   parameter int DEPTH = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_vld,
   input  logic [DW-1:0] in_data,
   output logic          out_vld,
   output logic [DW-1:0] out_data,
   output logic          pend
);

   logic [DEPTH-1:0]         vld_pipe;
   logic [DEPTH-1:0][DW-1:0] dat_pipe;

   // valid bits: unconditional shift, flushed stages beyond the input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= in_vld;
         for (int i = 1; i < DEPTH; i++)
            vld_pipe[i] <= flush ? 1'b0 : vld_pipe[i-1];
      end
   end

   // data payload: free-running shift, no reset needed
   always_ff @(posedge clk) begin
      dat_pipe[0] <= in_data;
      for (int i = 1; i < DEPTH; i++)
         dat_pipe[i] <= dat_pipe[i-1];
   end

   // pend: something will still occupy the line after this edge, given
   // that nothing new enters (true while draining)
   always_comb begin
      pend = 1'b0;
      for (int i = 0; i < DEPTH-1; i++)
         pend = pend | vld_pipe[i];
   end

   assign out_vld  = vld_pipe[DEPTH-1];
   assign out_data = dat_pipe[DEPTH-1];

endmodule

// File: rtl/adder_result_checker.sv
// Self-checking stage behind the pipelined adder: recomputes the sum from
// the operand stream, delays it to line up with the adder output and keeps
// pass/fail statistics plus the first mismatching pair.
module adder_result_checker
   import adder_result_checker_pkg::*;
#(
   parameter int WIDTH   = ADDER_WIDTH,
   parameter int LATENCY = ADDER_LATENCY,
   parameter int CNT_W   = CHK_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stop,
   adder_result_checker_if.slave  bus,
   output logic                   busy,
   output logic                   done,
   output logic                   err_flag,
   output logic [CNT_W-1:0]       pass_cnt,
   output logic [CNT_W-1:0]       fail_cnt,
   output logic [WIDTH:0]         ff_got,
   output logic [WIDTH:0]         ff_exp
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   chk_state_t       state, state_nxt;
   logic             cap_vld;
   logic [WIDTH:0]   exp_cap;
   logic             cmp_vld;
   logic [WIDTH:0]   cmp_exp;
   logic [WIDTH:0]   got;
   logic             pend;

   // full-width golden sum, carry kept in the top bit
   assign exp_cap = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.c_in};

   // a start cycle already counts as running so its vector is kept
   assign cap_vld = bus.in_valid && (start || state == ST_RUN);
   assign got     = {bus.cout_in, bus.sum_in};

   result_delay_line #(
      .DW    (WIDTH+1),
      .DEPTH (LATENCY)
   ) u_dly (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (start),
      .in_vld   (cap_vld),
      .in_data  (exp_cap),
      .out_vld  (cmp_vld),
      .out_data (cmp_exp),
      .pend     (pend)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // next state: start always wins, stop only matters while running
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_RUN;
         ST_RUN:   if (start) state_nxt = ST_RUN;
                   else if (stop) state_nxt = ST_DRAIN;
         ST_DRAIN: if (start) state_nxt = ST_RUN;
                   else if (!pend) state_nxt = ST_DONE;
         ST_DONE:  if (start) state_nxt = ST_RUN;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_RUN) || (state == ST_DRAIN);
   assign done = (state == ST_DONE);

   // statistics and first-failure capture; start discards the compare
   // that would land on its own edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
         err_flag <= 1'b0;
         ff_got   <= '0;
         ff_exp   <= '0;
      end else if (start) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
         err_flag <= 1'b0;
         ff_got   <= '0;
         ff_exp   <= '0;
      end else if (cmp_vld) begin
         if (got == cmp_exp) begin
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
         end else begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
            if (!err_flag) begin
               ff_got <= got;
               ff_exp <= cmp_exp;
            end
            err_flag <= 1'b1;
         end
      end
   end

endmodule
